conv_layer_sched: RTL and testbench

Layer scheduler that sequences a chain of `conv2d_mem`-style layer engines. It issues each engine's `start`, waits for its `done`, and merges the active engine's `out_valid`/`out_data` stream into a single framed output. The output is tagged with layer index, filter index and map boundaries. It sits between the top-level inference control and the per-layer engines, and replaces software/testbench-side feature-map bookkeeping.

---
 rtl/conv_sched_pkg.sv | 18 +
 rtl/conv_sched_frame_cnt.sv | 52 +++++
 rtl/conv_layer_sched.sv | 191 +++++++++++++++++++
 tb/tb_conv_layer_sched.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_sched_pkg.sv
// Shared types and default widths for the conv layer scheduler.
package conv_sched_pkg;

    localparam int unsigned PIX_W  = 16;
    localparam int unsigned FLT_W  = 8;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_RUN,
        S_DRAIN,
        S_NEXT,
        S_FIN,
        S_ERR
    } state_e;

endpackage

// File: rtl/conv_sched_frame_cnt.sv
// Pixel/filter position counters for the active layer, with map framing flags.
module conv_sched_frame_cnt #(
    parameter int unsigned PIX_W = conv_sched_pkg::PIX_W,
    parameter int unsigned FLT_W = conv_sched_pkg::FLT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [PIX_W-1:0] pix_in,
    input  logic [FLT_W-1:0] flt_in,
    input  logic             beat,
    output logic [FLT_W-1:0] filter,
    output logic             sof_c,
    output logic             eom_c,
    output logic             layer_complete_c,
    output logic             cfg_zero_c
);

    logic [PIX_W-1:0] pix_q;
    logic [PIX_W-1:0] p_q;
    logic [FLT_W-1:0] flt_q;
    logic [FLT_W-1:0] f_q;

    // Map sizes are latched at layer start so later input changes are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_q <= '0;
            flt_q <= '0;
            p_q   <= '0;
            f_q   <= '0;
        end else if (load) begin
            pix_q <= pix_in;
            flt_q <= flt_in;
            p_q   <= '0;
            f_q   <= '0;
        end else if (beat) begin
            if (eom_c) begin
                p_q <= '0;
                f_q <= f_q + FLT_W'(1);
            end else begin
                p_q <= p_q + PIX_W'(1);
            end
        end
    end

    assign filter           = f_q;
    assign sof_c            = (p_q == '0);
    assign eom_c            = (p_q == pix_q - PIX_W'(1));
    assign layer_complete_c = eom_c && (f_q == flt_q - FLT_W'(1));
    assign cfg_zero_c       = (pix_q == '0) || (flt_q == '0);

endmodule

// File: rtl/conv_layer_sched.sv
// Sequences a chain of layer engines and merges their output into one tagged stream.
// Optional stall watchdog: define CONV_LAYER_SCHED_WATCHDOG_EN.
module conv_layer_sched #(
    parameter int unsigned NUM_LAYERS     = 4,
    parameter int unsigned DATA_W         = conv_sched_pkg::DATA_W,
    parameter int unsigned PIX_W          = conv_sched_pkg::PIX_W,
    parameter int unsigned FLT_W          = conv_sched_pkg::FLT_W,
    parameter int unsigned LID_W          = 2,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         run,
    output logic                         busy,
    output logic                         seq_done,
    output logic                         err,
    input  logic [NUM_LAYERS*PIX_W-1:0]  lyr_pixels,
    input  logic [NUM_LAYERS*FLT_W-1:0]  lyr_filters,
    output logic [NUM_LAYERS-1:0]        eng_start,
    input  logic [NUM_LAYERS-1:0]        eng_done,
    input  logic [NUM_LAYERS-1:0]        eng_valid,
    input  logic [NUM_LAYERS*DATA_W-1:0] eng_data,
    output logic                         m_valid,
    output logic [DATA_W-1:0]            m_data,
    output logic [LID_W-1:0]             m_layer,
    output logic [FLT_W-1:0]             m_filter,
    output logic                         m_sof,
    output logic                         m_eom
);

    import conv_sched_pkg::*;

    if (((1 << LID_W) < NUM_LAYERS) || (TIMEOUT_CYCLES == 0)) begin : g_bad_cfg
        $error("conv_layer_sched: LID_W too narrow for NUM_LAYERS or TIMEOUT_CYCLES is zero");
    end

    state_e state_q, state_d;

    logic [LID_W-1:0]      l_q, l_d;
    logic [NUM_LAYERS-1:0] start_d;
    logic                  busy_d, seq_done_d, err_d;
    logic                  load_c, beat_c, act_valid_c, act_done_c, wd_timeout_c;
    logic [FLT_W-1:0]      filter;
    logic                  sof_c, eom_c, layer_complete_c, cfg_zero_c;

    logic [PIX_W-1:0]  pix_arr [NUM_LAYERS];
    logic [FLT_W-1:0]  flt_arr [NUM_LAYERS];
    logic [DATA_W-1:0] dat_arr [NUM_LAYERS];

    for (genvar i = 0; i < NUM_LAYERS; i++) begin : g_slice
        assign pix_arr[i] = lyr_pixels[i*PIX_W +: PIX_W];
        assign flt_arr[i] = lyr_filters[i*FLT_W +: FLT_W];
        assign dat_arr[i] = eng_data[i*DATA_W +: DATA_W];
    end

    assign act_valid_c = eng_valid[l_q];
    assign act_done_c  = eng_done[l_q];
    assign beat_c      = (state_q == S_RUN) && act_valid_c;

    conv_sched_frame_cnt #(
        .PIX_W (PIX_W),
        .FLT_W (FLT_W)
    ) u_frame_cnt (
        .clk              (clk),
        .rst              (rst),
        .load             (load_c),
        .pix_in           (pix_arr[l_d]),
        .flt_in           (flt_arr[l_d]),
        .beat             (beat_c),
        .filter           (filter),
        .sof_c            (sof_c),
        .eom_c            (eom_c),
        .layer_complete_c (layer_complete_c),
        .cfg_zero_c       (cfg_zero_c)
    );

`ifdef CONV_LAYER_SCHED_WATCHDOG_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_q;

    // Counts cycles since the last start or accepted beat; wd_q is 0 in the start cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_q <= '0;
        end else if (load_c || beat_c) begin
            wd_q <= '0;
        end else if (state_q inside {S_START, S_RUN, S_DRAIN}) begin
            wd_q <= wd_q + WD_W'(1);
        end
    end

    assign wd_timeout_c = (state_q inside {S_RUN, S_DRAIN}) &&
                          (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
`else
    assign wd_timeout_c = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (run) state_d = S_START;
            S_START: state_d = cfg_zero_c ? S_ERR : S_RUN;
            S_RUN: begin
                if (beat_c && layer_complete_c) begin
                    state_d = act_done_c ? S_NEXT : S_DRAIN;
                end else if (act_done_c || (wd_timeout_c && !beat_c)) begin
                    state_d = S_ERR;
                end
            end
            S_DRAIN: begin
                if (act_valid_c || wd_timeout_c) begin
                    state_d = S_ERR;
                end else if (act_done_c) begin
                    state_d = S_NEXT;
                end
            end
            S_NEXT:  state_d = (l_q == LID_W'(NUM_LAYERS - 1)) ? S_FIN : S_START;
            S_FIN:   state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Registered outputs are computed from the next state so they align with it.
    always_comb begin
        l_d        = l_q;
        load_c     = 1'b0;
        start_d    = '0;
        err_d      = err_q_hold();
        busy_d     = state_d inside {S_START, S_RUN, S_DRAIN, S_NEXT};
        seq_done_d = (state_d == S_FIN);
        if ((state_q == S_IDLE) && (state_d == S_START)) begin
            l_d   = '0;
            err_d = 1'b0;
        end else if ((state_q == S_NEXT) && (state_d == S_START)) begin
            l_d = l_q + LID_W'(1);
        end
        if (state_d == S_ERR) begin
            err_d = 1'b1;
        end
        if (state_d == S_START) begin
            load_c = 1'b1;
            if ((pix_arr[l_d] != '0) && (flt_arr[l_d] != '0)) begin
                start_d = NUM_LAYERS'(1) << l_d;
            end
        end
    end

    function automatic logic err_q_hold();
        return err;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            l_q       <= '0;
            busy      <= 1'b0;
            seq_done  <= 1'b0;
            err       <= 1'b0;
            eng_start <= '0;
            m_valid   <= 1'b0;
            m_data    <= '0;
            m_layer   <= '0;
            m_filter  <= '0;
            m_sof     <= 1'b0;
            m_eom     <= 1'b0;
        end else begin
            l_q       <= l_d;
            busy      <= busy_d;
            seq_done  <= seq_done_d;
            err       <= err_d;
            eng_start <= start_d;
            m_valid   <= beat_c;
            if (beat_c) begin
                m_data   <= dat_arr[l_q];
                m_layer  <= l_q;
                m_filter <= filter;
                m_sof    <= sof_c;
                m_eom    <= eom_c;
            end
        end
    end

endmodule

// File: tb/tb_conv_layer_sched.sv
// Randomized self-checking bench for conv_layer_sched (two layers).
// Watchdog scenario runs only when CONV_LAYER_SCHED_WATCHDOG_EN is defined.
module tb_conv_layer_sched;

    localparam int unsigned NL = 2;
    localparam int unsigned DW = 32;
    localparam int unsigned PW = 16;
    localparam int unsigned FW = 8;
    localparam int unsigned LW = 1;

    logic               clk = 1'b0;
    logic               rst;
    logic               run;
    logic               busy, seq_done, err;
    logic [NL*PW-1:0]   lyr_pixels;
    logic [NL*FW-1:0]   lyr_filters;
    logic [NL-1:0]      eng_start;
    logic [NL-1:0]      eng_done;
    logic [NL-1:0]      eng_valid;
    logic [NL*DW-1:0]   eng_data;
    logic               m_valid;
    logic [DW-1:0]      m_data;
    logic [LW-1:0]      m_layer;
    logic [FW-1:0]      m_filter;
    logic               m_sof, m_eom;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int start_cnt [NL];
    int seq_cnt = 0;
    logic [63:0] exp_q [$];

    conv_layer_sched #(
        .NUM_LAYERS     (NL),
        .DATA_W         (DW),
        .PIX_W          (PW),
        .FLT_W          (FW),
        .LID_W          (LW),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .busy        (busy),
        .seq_done    (seq_done),
        .err         (err),
        .lyr_pixels  (lyr_pixels),
        .lyr_filters (lyr_filters),
        .eng_start   (eng_start),
        .eng_done    (eng_done),
        .eng_valid   (eng_valid),
        .eng_data    (eng_data),
        .m_valid     (m_valid),
        .m_data      (m_data),
        .m_layer     (m_layer),
        .m_filter    (m_filter),
        .m_sof       (m_sof),
        .m_eom       (m_eom)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Output monitor: every merged beat must match the model's next expected beat.
    always @(negedge clk) begin
        logic [63:0] e;
        if (!rst) begin
            for (int l = 0; l < NL; l++) if (eng_start[l]) start_cnt[l]++;
            if (seq_done) seq_cnt++;
            if (m_valid) begin
                if (exp_q.size() == 0) begin
                    chk("beat_unexpected", 64'(m_data), 64'hDEAD_BEEF_0000_0000);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat", 64'({m_layer, m_filter, m_sof, m_eom, m_data}), e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int p0, input int p1, input int f0, input int f1);
        lyr_pixels  = {PW'(p1), PW'(p0)};
        lyr_filters = {FW'(f1), FW'(f0)};
    endtask

    // Engine model: emits pix*flt beats (or stop_after), then done after done_gap cycles.
    task automatic drive_layer(input int l, input int pix, input int flt, input int stop_after,
                               input int done_gap, input bit busy_run, output int dc);
        int nb;
        logic [DW-1:0] d;
        nb = (stop_after < pix * flt) ? stop_after : pix * flt;
        dc = -1;
        for (int k = 0; k < nb; k++) begin
            repeat ($urandom_range(0, 2)) tick();
            d = $urandom;
            eng_valid[l] = 1'b1;
            eng_data[l*DW +: DW] = d;
            eng_valid[1-l] = 1'($urandom_range(0, 1));
            eng_data[(1-l)*DW +: DW] = $urandom;
            if (k == 0 && busy_run) run = 1'b1;
            exp_q.push_back(64'({1'(l), FW'(k / pix), (k % pix) == 0, (k % pix) == pix - 1, d}));
            if (k == nb - 1 && done_gap == 0) begin
                eng_done[l] = 1'b1;
                dc = cyc;
            end
            tick();
            eng_valid = '0;
            eng_done  = '0;
            run       = 1'b0;
        end
        if (done_gap > 0) begin
            repeat (done_gap - 1) tick();
            eng_done[l] = 1'b1;
            dc = cyc;
            tick();
            eng_done = '0;
        end
    endtask

    task automatic wait_start(input int l, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (eng_start[l]) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic pulse_run();
        run = 1'b1;
        tick();
        run = 1'b0;
    endtask

    task automatic full_seq(input int p0, input int p1, input int f0, input int f1,
                            input int g0, input int g1, input bit busy_run);
        int s0, s1, sd, dc;
        bit ok;
        s0 = start_cnt[0];
        s1 = start_cnt[1];
        sd = seq_cnt;
        set_cfg(p0, p1, f0, f1);
        pulse_run();
        chk("busy_after_run", 64'(busy), 64'd1);
        chk("start0_after_run", 64'(eng_start), 64'b01);
        chk("err_cleared_by_run", 64'(err), 64'd0);
        tick();
        chk("start0_one_cycle", 64'(eng_start), 64'd0);
        drive_layer(0, p0, f0, p0 * f0, g0, busy_run, dc);
        wait_start(1, ok);
        chk("start1_seen", 64'(ok), 64'd1);
        chk("handoff_latency", 64'(cyc - dc), 64'd2);
        tick();
        drive_layer(1, p1, f1, p1 * f1, g1, 1'b0, dc);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (seq_done) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk("seq_done_seen", 64'(ok), 64'd1);
        chk("seq_done_latency", 64'(cyc - dc), 64'd2);
        chk("busy_at_fin", 64'(busy), 64'd0);
        tick();
        chk("seq_done_one_cycle", 64'(seq_done), 64'd0);
        chk("start0_count", 64'(start_cnt[0] - s0), 64'd1);
        chk("start1_count", 64'(start_cnt[1] - s1), 64'd1);
        chk("seq_done_count", 64'(seq_cnt - sd), 64'd1);
        chk("beats_outstanding", 64'(exp_q.size()), 64'd0);
        chk("err_after_seq", 64'(err), 64'd0);
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({busy, seq_done, err, eng_start, m_valid, m_sof, m_eom, m_layer, m_filter, m_data});
    endfunction

    initial begin
        int dc, s1, s0, t0;
        bit ok;
        start_cnt[0] = 0;
        start_cnt[1] = 0;
        rst = 1'b1;
        run = 1'b0;
        eng_done = '0;
        eng_valid = '0;
        eng_data = '0;
        set_cfg(4, 2, 2, 3);
        repeat (3) tick();
        chk("reset_outputs", all_outs(), 64'd0);
        rst = 1'b0;
        repeat (2) tick();
        chk("idle_outputs", all_outs(), 64'd0);

        // Nominal sequence, done 3 cycles after each engine's last beat.
        full_seq(4, 2, 2, 3, 3, 3, 1'b0);
        // Done coincident with the final beat, and a run pulse while busy.
        full_seq(4, 2, 2, 3, 0, 0, 1'b1);

        // Premature done after 5 of 8 beats.
        s1 = start_cnt[1];
        set_cfg(4, 2, 2, 3);
        pulse_run();
        tick();
        drive_layer(0, 4, 2, 5, 1, 1'b0, dc);
        chk("early_done_err", 64'(err), 64'd1);
        chk("early_done_busy", 64'(busy), 64'd0);
        repeat (5) tick();
        chk("early_done_err_sticky", 64'(err), 64'd1);
        chk("early_done_no_start1", 64'(start_cnt[1] - s1), 64'd0);
        chk("early_done_beats", 64'(exp_q.size()), 64'd0);
        full_seq(1, 1, 1, 1, 1, 2, 1'b0);

        // Zero filters on layer 1.
        s1 = start_cnt[1];
        set_cfg(3, 2, 2, 0);
        pulse_run();
        tick();
        drive_layer(0, 3, 2, 6, 2, 1'b0, dc);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (err) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk("zero_flt_err_seen", 64'(ok), 64'd1);
        chk("zero_flt_err_latency", 64'(cyc - dc), 64'd3);
        chk("zero_flt_busy", 64'(busy), 64'd0);
        repeat (3) tick();
        chk("zero_flt_no_start1", 64'(start_cnt[1] - s1), 64'd0);

        // Reset in the middle of layer 1.
        set_cfg(2, 3, 2, 2);
        pulse_run();
        tick();
        drive_layer(0, 2, 2, 4, 1, 1'b0, dc);
        wait_start(1, ok);
        chk("rst_scn_start1", 64'(ok), 64'd1);
        tick();
        drive_layer(1, 3, 2, 2, -1, 1'b0, dc);
        repeat (2) tick();
        chk("rst_scn_beats", 64'(exp_q.size()), 64'd0);
        rst = 1'b1;
        #1;
        chk("rst_mid_outputs", all_outs(), 64'd0);
        exp_q.delete();
        tick();
        rst = 1'b0;
        s0 = start_cnt[0];
        s1 = start_cnt[1];
        repeat (4) tick();
        chk("post_rst_no_start", 64'((start_cnt[0] - s0) + (start_cnt[1] - s1)), 64'd0);
        chk("post_rst_idle", all_outs(), 64'd0);
        full_seq(3, 2, 1, 2, 2, 1, 1'b0);

        // Randomized configurations.
        for (int it = 0; it < 6; it++) begin
            full_seq($urandom_range(1, 5), $urandom_range(1, 5), $urandom_range(1, 3),
                     $urandom_range(1, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                     1'($urandom_range(0, 1)));
        end

`ifdef CONV_LAYER_SCHED_WATCHDOG_EN
        // Engine 0 never responds: watchdog fires 16 cycles after its start.
        s1 = start_cnt[1];
        set_cfg(4, 2, 2, 3);
        pulse_run();
        t0 = cyc;
        chk("wd_start0", 64'(eng_start), 64'b01);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (err) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk("wd_err_seen", 64'(ok), 64'd1);
        chk("wd_err_latency", 64'(cyc - t0), 64'd16);
        chk("wd_busy", 64'(busy), 64'd0);
        chk("wd_no_start1", 64'(start_cnt[1] - s1), 64'd0);
`else
        t0 = 0;
`endif

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
